// File: rtl/pipe_sub64_pkg.sv
// Shared constants for the pipelined subtractor: lookahead group width and
// default operand width.
package pipe_sub64_pkg;

   localparam int GROUP_W       = 4;
   localparam int DEFAULT_WIDTH = 64;

   function automatic int num_groups(input int w);
      return (w + GROUP_W - 1) / GROUP_W;
   endfunction

endpackage

// File: rtl/bla_half.sv
// Combinational borrow-lookahead subtract d = a - b - bin over W bits.
// Borrows ripple inside each GROUP_W-bit group; group borrows are resolved by lookahead.
module bla_half
   import pipe_sub64_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic [W-1:0] d,
   output logic         bout
);

   localparam int NG = num_groups(W);
   localparam int PW = NG * GROUP_W;

   logic [PW-1:0] w_a;
   logic [PW-1:0] w_b;
   logic [PW-1:0] w_g;
   logic [PW-1:0] w_p;
   logic [PW-1:0] w_c;
   logic [NG:0]   w_gc;

   // Padding bits (when W is not a multiple of GROUP_W) propagate: g=0, p=1.
   assign w_a = PW'(a);
   assign w_b = PW'(b);
   assign w_g = ~w_a & w_b;
   assign w_p = ~(w_a ^ w_b);

   always_comb begin
      logic gg;
      logic gp;
      w_gc    = '0;
      w_c     = '0;
      w_gc[0] = bin;
      for (int gi = 0; gi < NG; gi++) begin
         gg = 1'b0;
         gp = 1'b1;
         for (int k = 0; k < GROUP_W; k++) begin
            gg = w_g[gi*GROUP_W+k] | (w_p[gi*GROUP_W+k] & gg);
            gp = gp & w_p[gi*GROUP_W+k];
         end
         w_gc[gi+1] = gg | (gp & w_gc[gi]);
      end
      for (int gi = 0; gi < NG; gi++) begin
         w_c[gi*GROUP_W] = w_gc[gi];
         for (int k = 0; k < GROUP_W - 1; k++) begin
            w_c[gi*GROUP_W+k+1] = w_g[gi*GROUP_W+k] | (w_p[gi*GROUP_W+k] & w_c[gi*GROUP_W+k]);
         end
      end
   end

   assign d    = a ^ b ^ w_c[W-1:0];
   assign bout = w_gc[NG];

endmodule

// File: rtl/pipe_sub64.sv
// Two-stage valid/ready pipelined subtractor: S1 resolves the low half and its
// borrow, S2 finishes the high half and drives the registered result.
module pipe_sub64
   import pipe_sub64_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int HALF  = WIDTH / 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             bor_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff_out,
   output logic             bor_out
);

   logic            r_s1_valid;
   logic [HALF-1:0] r_s1_dlo;
   logic            r_s1_bor;
   logic [HALF-1:0] r_s1_ahi;
   logic [HALF-1:0] r_s1_bhi;
   logic            r_s2_valid;
   logic [WIDTH-1:0] r_diff;
   logic            r_bor;

   logic [HALF-1:0] w_dlo;
   logic            w_blo;
   logic [HALF-1:0] w_dhi;
   logic            w_bhi;
   logic            w_s2_adv;
   logic            w_s1_adv;

   bla_half #(.W(HALF)) u_bla_lo (
      .a    (a_in[HALF-1:0]),
      .b    (b_in[HALF-1:0]),
      .bin  (bor_in),
      .d    (w_dlo),
      .bout (w_blo)
   );

   bla_half #(.W(HALF)) u_bla_hi (
      .a    (r_s1_ahi),
      .b    (r_s1_bhi),
      .bin  (r_s1_bor),
      .d    (w_dhi),
      .bout (w_bhi)
   );

   assign w_s2_adv = ~r_s2_valid | out_ready;
   assign w_s1_adv = ~r_s1_valid | w_s2_adv;

   assign in_ready  = w_s1_adv;
   assign out_valid = r_s2_valid;
   assign diff_out  = r_diff;
   assign bor_out   = r_bor;

   // Payloads load only with a valid source so a stalled or idle output holds its value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_dlo   <= '0;
         r_s1_bor   <= 1'b0;
         r_s1_ahi   <= '0;
         r_s1_bhi   <= '0;
         r_s2_valid <= 1'b0;
         r_diff     <= '0;
         r_bor      <= 1'b0;
      end else begin
         if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
               r_s1_dlo <= w_dlo;
               r_s1_bor <= w_blo;
               r_s1_ahi <= a_in[WIDTH-1:HALF];
               r_s1_bhi <= b_in[WIDTH-1:HALF];
            end
         end
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_diff <= {w_dhi, r_s1_dlo};
               r_bor  <= w_bhi;
            end
         end
      end
   end

endmodule
